// File: rtl/acc_core_sequencer.sv
// rtl/acc_core_sequencer.sv - fetch/decode/execute sequencer for the accumulator datapath
//
// Ports:
//   CLK, Reset_n                      clock (rising edge), asynchronous active-low reset
//   start                             one-cycle pulse, (re)starts execution at pc 0 from IDLE/DONE
//   imem_req/imem_addr/imem_ack/imem_rdata   instruction fetch handshake (rdata valid with ack)
//   op, reg_exe, imm_exe, reg_to_acc, acc_to_reg, imm_out, reg_sel   ALU control bundle
//   sc_in                             carry/shift-in from the internal SC register
//   alu_sc_out, alu_zero, alu_branch_en      ALU results
//   acc_we, reg_we                    accumulator / register file write strobes
//   dmem_req/dmem_we/dmem_ack         data memory handshake (we: 1 = store)
//   done, pc                          halted flag, current program counter
module acc_core_sequencer #(
    parameter int PC_W  = 8,
    parameter int IMM_W = 4
) (
    input  logic            CLK,
    input  logic            Reset_n,
    input  logic            start,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [8:0]      imem_rdata,
    output logic [3:0]      op,
    output logic            reg_exe,
    output logic            imm_exe,
    output logic            reg_to_acc,
    output logic            acc_to_reg,
    output logic [7:0]      imm_out,
    output logic [3:0]      reg_sel,
    output logic            sc_in,
    input  logic            alu_sc_out,
    input  logic            alu_zero,
    input  logic            alu_branch_en,
    output logic            acc_we,
    output logic            reg_we,
    output logic            dmem_req,
    output logic            dmem_we,
    input  logic            dmem_ack,
    output logic            done,
    output logic [PC_W-1:0] pc
);

    localparam logic [3:0] OP_ADD = 4'h0, OP_SUB = 4'h1, OP_BEQ = 4'h2, OP_SL = 4'h3,
                           OP_SR = 4'h4, OP_LW = 4'h5, OP_SW = 4'h6, OP_MOV = 4'h7,
                           OP_ASSIGN = 4'h8, OP_BGE = 4'h9, OP_BNE = 4'hA, OP_AND = 4'hB,
                           OP_OR = 4'hC, OP_JMP = 4'hD, OP_HALT = 4'hF;

    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_EXEC, S_MEM, S_DONE} state_t;

    state_t          state;
    logic [PC_W-1:0] pc_q;
    logic            sc_q;
    logic [8:0]      ir_q;

    logic [3:0]      ir_op;
    logic            ir_mode;
    logic            in_exec, in_mem;
    logic            is_mov, is_lw, is_sw, is_halt;
    logic            writes_acc, updates_sc;
    logic [PC_W-1:0] pc_plus1, pc_plus2, jmp_off, pc_next_exec;

    assign ir_op    = ir_q[8:5];
    assign ir_mode  = ir_q[4];
    assign in_exec  = (state == S_EXEC);
    assign in_mem   = (state == S_MEM);
    assign is_mov   = (ir_op == OP_MOV);
    assign is_lw    = (ir_op == OP_LW);
    assign is_sw    = (ir_op == OP_SW);
    assign is_halt  = (ir_op == OP_HALT);
    assign pc_plus1 = pc_q + PC_W'(1);
    assign pc_plus2 = pc_q + PC_W'(2);
    // 5-bit signed jump offset, so JMP reaches -16..+15 around the current pc
    assign jmp_off  = {{(PC_W-5){ir_q[4]}}, ir_q[4:0]};

    always_comb begin
        writes_acc = 1'b0;
        updates_sc = 1'b0;
        case (ir_op)
            OP_ADD, OP_SUB, OP_SL, OP_SR: begin
                writes_acc = 1'b1;
                updates_sc = 1'b1;
            end
            OP_AND, OP_OR, OP_ASSIGN: writes_acc = 1'b1;
            OP_MOV:                   writes_acc = ir_mode;
            default: ;
        endcase
    end

    always_comb begin
        pc_next_exec = pc_plus1;
        case (ir_op)
            // a taken branch skips the following instruction (normally a JMP)
            OP_BEQ, OP_BGE, OP_BNE: pc_next_exec = alu_branch_en ? pc_plus2 : pc_plus1;
            OP_JMP:                 pc_next_exec = pc_q + jmp_off;
            // loads/stores advance pc when the data access completes; HALT stays put
            OP_LW, OP_SW, OP_HALT:  pc_next_exec = pc_q;
            default: ;
        endcase
    end

    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            state <= S_IDLE;
            pc_q  <= '0;
            sc_q  <= 1'b0;
            ir_q  <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        pc_q  <= '0;
                        state <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    if (imem_ack) begin
                        ir_q  <= imem_rdata;
                        state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (updates_sc) sc_q <= alu_sc_out;
                    pc_q <= pc_next_exec;
                    if (is_lw || is_sw) state <= S_MEM;
                    else if (is_halt)   state <= S_DONE;
                    else                state <= S_FETCH;
                end
                S_MEM: begin
                    if (dmem_ack) begin
                        pc_q  <= pc_plus1;
                        state <= S_FETCH;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Outputs decode purely from registered state/IR (plus dmem_ack for the load strobe),
    // so an asynchronous reset clears every request and strobe immediately.
    always_comb begin
        op         = 4'h0;
        reg_exe    = 1'b0;
        imm_exe    = 1'b0;
        reg_to_acc = 1'b0;
        acc_to_reg = 1'b0;
        imm_out    = 8'h00;
        reg_sel    = 4'h0;
        if (in_exec || in_mem) begin
            op         = ir_op;
            reg_exe    = !is_mov && ir_mode;
            imm_exe    = !is_mov && !ir_mode;
            reg_to_acc = is_mov && ir_mode;
            acc_to_reg = is_mov && !ir_mode;
            imm_out    = {{(8-IMM_W){1'b0}}, ir_q[IMM_W-1:0]};
            reg_sel    = ir_q[3:0];
        end
    end

    assign imem_req  = (state == S_FETCH);
    assign imem_addr = pc_q;
    assign pc        = pc_q;
    assign sc_in     = sc_q;
    assign acc_we    = (in_exec && writes_acc) || (in_mem && is_lw && dmem_ack);
    assign reg_we    = in_exec && is_mov && !ir_mode;
    assign dmem_req  = in_mem;
    assign dmem_we   = in_mem && is_sw;
    assign done      = (state == S_DONE) || (in_exec && is_halt);

    // ZERO is folded into alu_branch_en by the ALU; kept on the port for the bundle
    logic unused_ok;
    assign unused_ok = alu_zero;

endmodule

// File: tb/tb_acc_core_sequencer.sv
// tb/tb_acc_core_sequencer.sv - self-checking bench for acc_core_sequencer
module tb_acc_core_sequencer;

    localparam int OP_ADD = 0, OP_SUB = 1, OP_BEQ = 2, OP_SL = 3, OP_SR = 4, OP_LW = 5,
                   OP_SW = 6, OP_MOV = 7, OP_ASSIGN = 8, OP_BGE = 9, OP_BNE = 10,
                   OP_AND = 11, OP_OR = 12, OP_JMP = 13, OP_NOP = 14, OP_HALT = 15;

    logic       CLK = 1'b0;
    logic       Reset_n, start, imem_req, imem_ack;
    logic [7:0] imem_addr, imm_out, pc;
    logic [8:0] imem_rdata;
    logic [3:0] op, reg_sel;
    logic       reg_exe, imm_exe, reg_to_acc, acc_to_reg, sc_in;
    logic       alu_sc_out, alu_zero, alu_branch_en;
    logic       acc_we, reg_we, dmem_req, dmem_we, dmem_ack, done;

    int n_chk = 0;
    int n_fail = 0;
    int cyc_cnt = 0;
    int exec_cyc;
    int m_pc;
    logic m_sc;

    acc_core_sequencer #(.PC_W(8), .IMM_W(4)) dut (
        .CLK(CLK), .Reset_n(Reset_n), .start(start),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .op(op), .reg_exe(reg_exe), .imm_exe(imm_exe), .reg_to_acc(reg_to_acc),
        .acc_to_reg(acc_to_reg), .imm_out(imm_out), .reg_sel(reg_sel), .sc_in(sc_in),
        .alu_sc_out(alu_sc_out), .alu_zero(alu_zero), .alu_branch_en(alu_branch_en),
        .acc_we(acc_we), .reg_we(reg_we), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_ack(dmem_ack), .done(done), .pc(pc)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc_cnt <= cyc_cnt + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [8:0] mk(input int opc, input int mode, input int low);
        return 9'(opc * 32 + mode * 16 + (low & 15));
    endfunction

    function automatic logic [8:0] mk_jmp(input int off);
        return 9'(OP_JMP * 32 + (off & 31));
    endfunction

    function automatic logic exp_acc_we(input int opc, input int mode);
        return (opc inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SL, OP_SR, OP_ASSIGN}) ||
               (opc == OP_MOV && mode == 1);
    endfunction

    task automatic idle_outputs(input string tag);
        chk({tag, "_op"}, op, 0);
        chk({tag, "_acc_we"}, acc_we, 0);
        chk({tag, "_reg_we"}, reg_we, 0);
        chk({tag, "_dmem_req"}, dmem_req, 0);
    endtask

    task automatic do_start();
        start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        m_pc = 0;
    endtask

    // Runs one instruction at the ISA level: fetch with fwait stall cycles, one EXEC cycle
    // with the given ALU results, and for LW/SW a data phase with mwait stall cycles.
    task automatic exec_one(input logic [8:0] ins, input int fwait, input int mwait,
                            input logic sco, input logic br);
        int opc, mode, low, off;
        opc  = int'(ins[8:5]);
        mode = int'(ins[4]);
        low  = int'(ins[3:0]);
        for (int w = 0; w < fwait; w++) begin
            start = 1'($urandom_range(0, 1));
            imem_ack = 1'b0;
            #1;
            chk("fetch_req", imem_req, 1);
            chk("fetch_addr", imem_addr, m_pc);
            idle_outputs("fetch");
            @(negedge CLK);
        end
        start = 1'b0;
        imem_ack = 1'b1;
        imem_rdata = ins;
        #1;
        chk("fetch_req", imem_req, 1);
        chk("fetch_addr", imem_addr, m_pc);
        @(negedge CLK);
        imem_ack = 1'b0;
        imem_rdata = 9'($urandom);
        alu_sc_out = sco;
        alu_branch_en = br;
        alu_zero = 1'($urandom_range(0, 1));
        #1;
        exec_cyc = cyc_cnt;
        chk("exec_op", op, opc);
        chk("exec_reg_exe", reg_exe, (opc != OP_MOV) && mode == 1);
        chk("exec_imm_exe", imm_exe, (opc != OP_MOV) && mode == 0);
        chk("exec_reg_to_acc", reg_to_acc, (opc == OP_MOV) && mode == 1);
        chk("exec_acc_to_reg", acc_to_reg, (opc == OP_MOV) && mode == 0);
        chk("exec_imm_out", imm_out, low);
        chk("exec_reg_sel", reg_sel, low);
        chk("exec_sc_in", sc_in, m_sc);
        chk("exec_acc_we", acc_we, exp_acc_we(opc, mode));
        chk("exec_reg_we", reg_we, (opc == OP_MOV) && mode == 0);
        chk("exec_done", done, opc == OP_HALT);
        chk("exec_imem_req", imem_req, 0);
        chk("exec_pc", pc, m_pc);
        if (opc inside {OP_ADD, OP_SUB, OP_SL, OP_SR}) m_sc = sco;
        if (opc inside {OP_BEQ, OP_BGE, OP_BNE}) m_pc = (m_pc + (br ? 2 : 1)) % 256;
        else if (opc == OP_JMP) begin
            off = mode * 16 + low;
            if (off >= 16) off -= 32;
            m_pc = ((m_pc + off) % 256 + 256) % 256;
        end else if (!(opc inside {OP_LW, OP_SW, OP_HALT})) m_pc = (m_pc + 1) % 256;
        @(negedge CLK);
        alu_sc_out = 1'b0;
        alu_branch_en = 1'b0;
        if (opc == OP_LW || opc == OP_SW) begin
            for (int w = 0; w < mwait; w++) begin
                dmem_ack = 1'b0;
                #1;
                chk("mem_req", dmem_req, 1);
                chk("mem_we", dmem_we, opc == OP_SW);
                chk("mem_acc_we", acc_we, 0);
                chk("mem_op", op, opc);
                @(negedge CLK);
            end
            dmem_ack = 1'b1;
            #1;
            chk("mem_req", dmem_req, 1);
            chk("mem_we", dmem_we, opc == OP_SW);
            chk("mem_ack_acc_we", acc_we, opc == OP_LW);
            chk("mem_reg_we", reg_we, 0);
            @(negedge CLK);
            dmem_ack = 1'b0;
            m_pc = (m_pc + 1) % 256;
        end
        if (opc == OP_HALT) begin
            #1;
            chk("halt_done", done, 1);
            chk("halt_pc", pc, m_pc);
            chk("halt_imem_req", imem_req, 0);
        end
    endtask

    initial begin
        int t0;
        Reset_n = 1'b0; start = 1'b0; imem_ack = 1'b0; imem_rdata = '0;
        alu_sc_out = 1'b0; alu_zero = 1'b0; alu_branch_en = 1'b0; dmem_ack = 1'b0;
        m_pc = 0; m_sc = 1'b0;
        repeat (2) @(negedge CLK);
        #1;
        chk("rst_imem_req", imem_req, 0);
        chk("rst_pc", pc, 0);
        chk("rst_done", done, 0);
        chk("rst_sc_in", sc_in, 0);
        idle_outputs("rst");
        @(negedge CLK);
        Reset_n = 1'b1;
        @(negedge CLK);

        // reset asserted mid-FETCH
        do_start();
        #1;
        chk("fetch_before_rst", imem_req, 1);
        Reset_n = 1'b0;
        #1;
        chk("midfetch_rst_req", imem_req, 0);
        chk("midfetch_rst_pc", pc, 0);
        chk("midfetch_rst_done", done, 0);
        idle_outputs("midfetch_rst");
        @(negedge CLK);
        Reset_n = 1'b1;
        @(negedge CLK);

        // ASSIGN 5, ADD imm 3, HALT with zero-wait acks
        t0 = cyc_cnt;
        do_start();
        exec_one(mk(OP_ASSIGN, 0, 5), 0, 0, 1'b0, 1'b0);
        chk("prog_assign_cycle", exec_cyc - t0, 2);
        exec_one(mk(OP_ADD, 0, 3), 0, 0, 1'b0, 1'b0);
        chk("prog_add_cycle", exec_cyc - t0, 4);
        exec_one(mk(OP_HALT, 0, 0), 0, 0, 1'b0, 1'b0);
        chk("prog_done_cycle", exec_cyc - t0, 6);
        chk("prog_final_pc", pc, 2);

        // branches: taken skip, then not-taken falling into a backward JMP
        do_start();
        for (int i = 0; i < 4; i++) exec_one(mk(OP_NOP, 0, 0), 0, 0, 1'b0, 1'b0);
        exec_one(mk(OP_BEQ, 0, 7), 1, 0, 1'b0, 1'b1);
        chk("beq_taken_pc", pc, 6);
        exec_one(mk_jmp(-2), 0, 0, 1'b0, 1'b0);
        exec_one(mk(OP_BEQ, 0, 7), 0, 0, 1'b0, 1'b0);
        chk("beq_not_taken_pc", pc, 5);
        exec_one(mk_jmp(-3), 0, 0, 1'b0, 1'b0);
        chk("jmp_back_pc", pc, 2);

        // carry register: set by ADD, kept across AND, observed by next ADD
        exec_one(mk(OP_ADD, 1, 3), 0, 0, 1'b1, 1'b0);
        exec_one(mk(OP_AND, 0, 4), 1, 0, 1'b0, 1'b0);
        exec_one(mk(OP_ADD, 0, 5), 0, 0, 1'b0, 1'b0);

        // loads and stores
        exec_one(mk(OP_LW, 1, 6), 0, 3, 1'b0, 1'b0);
        exec_one(mk(OP_SW, 1, 7), 0, 0, 1'b0, 1'b0);
        exec_one(mk(OP_LW, 0, 8), 2, 0, 1'b0, 1'b0);

        // pc wrap, with stray start pulses during fetch stalls
        exec_one(mk_jmp(-9), 2, 0, 1'b0, 1'b0);
        chk("wrap_pc_255", pc, 255);
        exec_one(mk_jmp(1), 3, 0, 1'b0, 1'b0);
        chk("wrap_pc_0", pc, 0);

        // randomized instruction stream (no HALT)
        for (int i = 0; i < 200; i++) begin
            exec_one(mk($urandom_range(0, 14), $urandom_range(0, 1), $urandom_range(0, 15)),
                     $urandom_range(0, 3), $urandom_range(0, 3),
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        exec_one(mk(OP_HALT, 0, 0), 1, 0, 1'b0, 1'b0);

        // restart from DONE, then reset in the middle of a data access
        do_start();
        exec_one(mk(OP_NOP, 0, 0), 0, 0, 1'b0, 1'b0);
        imem_ack = 1'b1;
        imem_rdata = mk(OP_LW, 0, 1);
        @(negedge CLK);
        imem_ack = 1'b0;
        @(negedge CLK);
        #1;
        chk("mem_before_rst", dmem_req, 1);
        Reset_n = 1'b0;
        #1;
        chk("midmem_rst_req", dmem_req, 0);
        chk("midmem_rst_pc", pc, 0);
        idle_outputs("midmem_rst");
        dmem_ack = 1'b1;
        imem_ack = 1'b1;
        @(negedge CLK);
        Reset_n = 1'b1;
        @(negedge CLK);
        #1;
        chk("late_ack_imem_req", imem_req, 0);
        chk("late_ack_pc", pc, 0);
        chk("late_ack_done", done, 0);
        idle_outputs("late_ack");
        dmem_ack = 1'b0;
        imem_ack = 1'b0;
        @(negedge CLK);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
